// File: rtl/relay_link_arbiter.sv
// relay_link_arbiter: grants the half-duplex relay link to reader side (A) or tag side (B) with turnaround guard and watchdog
module relay_link_arbiter #(
  parameter int GUARD_CYCLES     = 16,
  parameter int MAX_FRAME_CYCLES = 4096,
  parameter int CNT_W            = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       frame_done,
  input  logic [2:0] mode_req,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       enc_en,
  output logic       dec_en,
  output logic [2:0] mode_active,
  output logic       abort,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, GUARD} state_t;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d, gd_q, gd_d;
  logic last_b_q, last_b_d;
  logic req_a_q, req_b_q;
  logic [2:0] mode_q, mode_d;
  logic gnt_a_q, gnt_b_q, dec_en_q, busy_q, abort_q, abort_d;
  logic own_req, wd_exp, entering;
  // requests are registered first, so arbitration sees them one edge after sampling
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    mode_d   = mode_q;
    abort_d  = 1'b0;
    own_req  = (state_q == GRANT_A) ? req_a_q : req_b_q;
    wd_exp   = wd_q == WD_LAST;
    case (state_q)
      IDLE: begin
        mode_d = mode_req;
        if (req_a_q && (!req_b_q || last_b_q)) begin
          state_d  = GRANT_A;
          last_b_d = 1'b0;
        end else if (req_b_q) begin
          state_d  = GRANT_B;
          last_b_d = 1'b1;
        end
      end
      GRANT_A, GRANT_B: begin
        if (frame_done || !own_req || wd_exp) begin
          state_d = GUARD;
          abort_d = wd_exp && !frame_done && own_req;
        end
      end
      default: state_d = (gd_q == GD_LAST) ? IDLE : GUARD;
    endcase
    entering = state_d != state_q;
    wd_d     = entering ? '0 : (wd_q == CNT_MAX) ? wd_q : wd_q + 1'b1;
    gd_d     = entering ? '0 : (gd_q == CNT_MAX) ? gd_q : gd_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wd_q     <= '0;
      gd_q     <= '0;
      last_b_q <= 1'b1;
      req_a_q  <= 1'b0;
      req_b_q  <= 1'b0;
      mode_q   <= 3'b000;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      dec_en_q <= 1'b1;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      gd_q     <= gd_d;
      last_b_q <= last_b_d;
      req_a_q  <= req_a;
      req_b_q  <= req_b;
      mode_q   <= mode_d;
      gnt_a_q  <= state_d == GRANT_A;
      gnt_b_q  <= state_d == GRANT_B;
      dec_en_q <= state_d == IDLE;
      busy_q   <= state_d != IDLE;
      abort_q  <= abort_d;
    end
  end
  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign enc_en      = gnt_a_q | gnt_b_q;
  assign dec_en      = dec_en_q;
  assign busy        = busy_q;
  assign abort       = abort_q;
  assign mode_active = mode_q;
endmodule

// File: tb/tb_relay_link_arbiter.sv
// tb_relay_link_arbiter: scenario tasks with an expected-value queue for the relay link arbiter
module tb_relay_link_arbiter;
  logic clk = 1'b0, reset = 1'b0, req_a = 1'b0, req_b = 1'b0, frame_done = 1'b0;
  logic [2:0] mode_req = 3'b000;
  logic gnt_a, gnt_b, enc_en, dec_en, abort, busy;
  logic [2:0] mode_active;
  int checks = 0, errors = 0;
  typedef struct {string name; int val;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  relay_link_arbiter dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .frame_done(frame_done),
    .mode_req(mode_req), .gnt_a(gnt_a), .gnt_b(gnt_b), .enc_en(enc_en), .dec_en(dec_en),
    .mode_active(mode_active), .abort(abort), .busy(busy)
  );

  always @(negedge clk) if (reset) begin
    checks++;
    if ((gnt_a & gnt_b) !== 1'b0 || (enc_en & dec_en) !== 1'b0 || enc_en !== (gnt_a | gnt_b)) begin
      errors++;
      $display("FAIL invariant: gnt_a=%b gnt_b=%b enc_en=%b dec_en=%b required exclusive grants and enc/dec", gnt_a, gnt_b, enc_en, dec_en);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    frame_done = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      tick;
      if (gnt_a || gnt_b) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 100; i++) begin
      if (dec_en) break;
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_a = 1'b1;
    tick;
    tick;
    checks++;
    if ({gnt_a, gnt_b, enc_en, dec_en, abort, busy, mode_active} !== 9'b0001_00_000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", {gnt_a, gnt_b, enc_en, dec_en, abort, busy, mode_active}, 9'b0001_00_000);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL grant_latency_early: gnt_a=%b required 0", gnt_a);
    end
    tick;
    checks++;
    if ({gnt_a, enc_en, dec_en, busy} !== 4'b1101) begin
      errors++;
      $display("FAIL grant_latency: {gnt_a,enc_en,dec_en,busy}=%b required 1101", {gnt_a, enc_en, dec_en, busy});
    end
  endtask

  task automatic test_single_grant;
    int cnt;
    repeat (19) tick;
    checks++;
    if (gnt_a !== 1'b1) begin
      errors++;
      $display("FAIL grant_hold: gnt_a=%b required 1", gnt_a);
    end
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    req_a = 1'b0;
    checks++;
    if ({gnt_a, dec_en, busy, abort} !== 4'b0010) begin
      errors++;
      $display("FAIL frame_done_end: {gnt_a,dec_en,busy,abort}=%b required 0010", {gnt_a, dec_en, busy, abort});
    end
    exp_q.push_back('{"guard_len", 16});
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (dec_en) break;
      cnt++;
    end
    e = exp_q.pop_front();
    checks++;
    if (cnt !== e.val || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got %0d cycles busy=%b required %0d cycles busy=0", e.name, cnt, busy, e.val);
    end
  endtask

  task automatic test_round_robin;
    int cyc, gap, who;
    apply_reset;
    req_a = 1'b1;
    req_b = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back('{"rr_order", k % 2});
    wait_grant(cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL rr_first_latency: got %0d edges required 2", cyc);
    end
    for (int k = 0; k < 4; k++) begin
      who = gnt_b ? 1 : 0;
      e = exp_q.pop_front();
      checks++;
      if (who !== e.val || (gnt_a && gnt_b)) begin
        errors++;
        $display("FAIL %s[%0d]: got %0d (a=%b b=%b) required %0d", e.name, k, who, gnt_a, gnt_b, e.val);
      end
      repeat (4) tick;
      frame_done = 1'b1;
      tick;
      frame_done = 1'b0;
      if (k < 3) begin
        gap = 1;
        for (int i = 0; i < 60; i++) begin
          tick;
          if (gnt_a || gnt_b) break;
          gap++;
        end
        checks++;
        if (gap !== 17) begin
          errors++;
          $display("FAIL rr_gap[%0d]: got %0d idle cycles required 17", k, gap);
        end
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    wait_idle;
  endtask

  task automatic test_watchdog;
    int cyc, cnt, early_abort;
    apply_reset;
    req_b = 1'b1;
    wait_grant(cyc);
    exp_q.push_back('{"wd_len", 4096});
    exp_q.push_back('{"wd_guard", 16});
    cnt = 0;
    early_abort = 0;
    while ((gnt_b === 1'b1) && cnt < 5000) begin
      if (abort) early_abort++;
      cnt++;
      tick;
    end
    req_b = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (cnt !== e.val || early_abort !== 0) begin
      errors++;
      $display("FAIL %s: got %0d cycles (abort during grant %0d) required %0d", e.name, cnt, early_abort, e.val);
    end
    checks++;
    if (abort !== 1'b1) begin
      errors++;
      $display("FAIL wd_abort: abort=%b required 1", abort);
    end
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (i == 0) begin
        checks++;
        if (abort !== 1'b0) begin
          errors++;
          $display("FAIL wd_abort_width: abort=%b required 0", abort);
        end
      end
      if (dec_en) break;
      cnt++;
    end
    e = exp_q.pop_front();
    checks++;
    if (cnt !== e.val) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", e.name, cnt, e.val);
    end
  endtask

  task automatic test_coincident;
    int cyc, cnt;
    apply_reset;
    req_a = 1'b1;
    wait_grant(cyc);
    cnt = 1;
    while (cnt < 4096 && gnt_a === 1'b1) begin
      tick;
      cnt++;
    end
    checks++;
    if (gnt_a !== 1'b1) begin
      errors++;
      $display("FAIL coinc_hold: gnt_a=%b at grant cycle %0d required 1", gnt_a, cnt);
    end
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    req_a = 1'b0;
    checks++;
    if ({gnt_a, abort} !== 2'b00) begin
      errors++;
      $display("FAIL coinc_no_abort: {gnt_a,abort}=%b required 00", {gnt_a, abort});
    end
    wait_idle;
  endtask

  task automatic test_mode;
    int cyc, bad;
    apply_reset;
    mode_req = 3'b001;
    tick;
    checks++;
    if (mode_active !== 3'b001) begin
      errors++;
      $display("FAIL mode_idle: got %b required 001", mode_active);
    end
    req_a = 1'b1;
    wait_grant(cyc);
    mode_req = 3'b100;
    bad = 0;
    repeat (5) begin
      tick;
      if (mode_active !== 3'b001) bad++;
    end
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    req_a = 1'b0;
    for (int i = 0; i < 100 && !dec_en; i++) begin
      if (mode_active !== 3'b001) bad++;
      tick;
    end
    checks++;
    if (bad !== 0 || mode_active !== 3'b001) begin
      errors++;
      $display("FAIL mode_frozen: %0d changed cycles, mode_active=%b on IDLE entry required 001", bad, mode_active);
    end
    tick;
    checks++;
    if (mode_active !== 3'b100) begin
      errors++;
      $display("FAIL mode_update: got %b required 100", mode_active);
    end
    mode_req = 3'b000;
  endtask

  task automatic test_async_reset;
    int cyc;
    apply_reset;
    req_a = 1'b1;
    wait_grant(cyc);
    repeat (3) tick;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({gnt_a, enc_en, busy, dec_en, abort} !== 5'b00010) begin
      errors++;
      $display("FAIL async_reset: {gnt_a,enc_en,busy,dec_en,abort}=%b required 00010", {gnt_a, enc_en, busy, dec_en, abort});
    end
    req_b = 1'b1;
    tick;
    reset = 1'b1;
    wait_grant(cyc);
    checks++;
    if (cyc !== 2 || gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_rr: edges=%0d gnt_a=%b gnt_b=%b required 2,1,0", cyc, gnt_a, gnt_b);
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_grant;
    test_round_robin;
    test_watchdog;
    test_coincident;
    test_mode;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/relay_link_arbiter.md
Name: relay_link_arbiter

Overview:
- Schedules the single half-duplex relay link between two requesters: the reader-side forwarder (A) and the tag-side forwarder (B).
- Grants the encoder to exactly one requester at a time and enforces a turnaround guard before the link direction may change.
- Bounds each grant with a watchdog.
- Latches the relay mode so that mode changes only take effect while the link is idle.
- Sits between the hi_simulate mode register and the relay encode/decode/mode datapath.

Parameters:
- GUARD_CYCLES, 16: idle cycles forced after every grant before the next grant; must be at least 1.
- MAX_FRAME_CYCLES, 4096: watchdog limit on grant length, in cycles; must be at least 2.
- CNT_W, 13: counter width; must satisfy 2^CNT_W > max(GUARD_CYCLES, MAX_FRAME_CYCLES).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_a  input  1  reader-side requester has a frame to send; level-sensitive.
- req_b  input  1  tag-side requester has a frame to send; level-sensitive.
- frame_done  input  1  one-cycle pulse from the encoder at end of frame.
- mode_req  input  3  requested relay mode (hi_simulate_mod_type encoding).
- gnt_a  output  1  link granted to A.
- gnt_b  output  1  link granted to B.
- enc_en  output  1  relay encoder enabled; equals gnt_a | gnt_b.
- dec_en  output  1  relay decoder enabled; high only in IDLE.
- mode_active  output  3  mode in force for the datapath.
- abort  output  1  one-cycle pulse when the watchdog terminates a grant.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state=IDLE, all counters 0, last_grant=B (so A wins first);
  - gnt_a=gnt_b=enc_en=abort=busy=0, dec_en=1, mode_active=3'b000.
- All outputs are registered.
- States: IDLE, GRANT_A, GRANT_B, GUARD.
- IDLE:
  - mode_active <= mode_req every cycle.
  - If req_a and not req_b, go to GRANT_A. If req_b and not req_a, go to GRANT_B.
  - If both are high, grant the requester other than last_grant (round-robin), then update last_grant.
  - Latency: request sampled high at edge N gives the grant output high after edge N+1. dec_en falls on the same edge.
- GRANT_x:
  - gnt_x=1, enc_en=1, dec_en=0, busy=1. mode_active is frozen; mode_req changes are ignored until IDLE.
  - The watchdog counter starts at 0 on entry and increments each cycle.
  - Exit to GUARD on the first of:
    - frame_done=1;
    - req_x=0 (requester withdrew);
    - watchdog reaching MAX_FRAME_CYCLES-1. This case also pulses abort=1 for exactly one cycle, coincident with the first GUARD cycle.
  - If frame_done and watchdog expiry coincide, treat it as a normal completion: no abort.
  - frame_done pulses received in IDLE or GUARD are ignored.
- GUARD:
  - gnt_a=gnt_b=enc_en=0, dec_en=0, busy=1.
  - Guard counter runs 0..GUARD_CYCLES-1, then returns to IDLE. GUARD therefore lasts exactly GUARD_CYCLES cycles.
  - Requests arriving during GUARD are held by the requester (level) and arbitrated on the first IDLE cycle.
- Minimum grant: 1 cycle. Minimum spacing between grants: GUARD_CYCLES+1 cycles (guard plus one IDLE arbitration cycle).
- Invariants:
  - gnt_a & gnt_b is never 1.
  - enc_en & dec_en is never 1.
  - mode_active changes only while in IDLE.
- Counters saturate and never wrap. Both reset to 0 on every state entry.
- Reset asserted mid-grant: the grant drops immediately (asynchronously) with no abort pulse. After release, operation resumes in IDLE with last_grant=B.

Test Plan:
- Reset release with req_a=1, req_b=0: gnt_a=1 and enc_en=1 two edges after release. frame_done after 20 cycles gives gnt_a=0 next edge, then exactly 16 GUARD cycles with dec_en=0, then IDLE with dec_en=1.
- req_a=req_b=1 held continuously: grants alternate A, B, A, B (first is A). Each is separated by 17 cycles with gnt_a=gnt_b=0, and the two grants never overlap.
- req_b held with no frame_done: gnt_b drops after exactly 4096 cycles, with abort high for exactly 1 cycle and then the 16-cycle guard.
- frame_done coincident with the 4096th grant cycle: grant ends with abort=0.
- mode_req changed from 3'b001 to 3'b100 mid-grant: mode_active stays 3'b001 through GRANT and GUARD, and becomes 3'b100 one edge after IDLE is entered.
- reset pulsed low mid-GRANT_A: gnt_a, enc_en and busy go to 0 without waiting for a clock edge, and dec_en=1. With both requests high after release, A is granted first.
